// File: rtl/msx_slot_master.sv
// MSX cartridge slot bus initiator: turns single-byte valid/ready requests into
// Z80-style I/O or memory cycles on the slot pins, with WAIT extension and timeout.
module msx_slot_master #(
    parameter int unsigned SETUP_CYCLES  = 3,
    parameter int unsigned STROBE_CYCLES = 12,
    parameter int unsigned HOLD_CYCLES   = 3,
    parameter int unsigned WAIT_TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_address,
    input  logic        bus_ioreq,
    input  logic        bus_write,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_rdata_en,
    output logic [15:0] p_slot_address,
    output logic        p_slot_iorq_n,
    output logic        p_slot_mreq_n,
    output logic        p_slot_rd_n,
    output logic        p_slot_wr_n,
    output logic [7:0]  p_slot_data_out,
    output logic        p_slot_data_oe,
    input  logic [7:0]  p_slot_data_in,
    input  logic        p_slot_wait,
    output logic        p_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
    localparam logic [9:0] EXT_MAX     = 10'(WAIT_TIMEOUT);

    state_t      r_state,   w_state;
    logic [7:0]  r_phase,   w_phase;
    logic [9:0]  r_ext,     w_ext;
    logic        r_io,      w_io;
    logic        r_wr,      w_wr;
    logic        r_ready,   w_ready;
    logic [7:0]  r_rdata,   w_rdata;
    logic        r_rdata_en, w_rdata_en;
    logic [15:0] r_addr,    w_addr;
    logic        r_iorq_n,  w_iorq_n;
    logic        r_mreq_n,  w_mreq_n;
    logic        r_rd_n,    w_rd_n;
    logic        r_wr_n,    w_wr_n;
    logic [7:0]  r_dout,    w_dout;
    logic        r_oe,      w_oe;
    logic        r_timeout, w_timeout;
    logic        r_wait_meta;
    logic        r_wait_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_ext       <= '0;
            r_io        <= 1'b0;
            r_wr        <= 1'b0;
            r_ready     <= 1'b0;
            r_rdata     <= 8'hFF;
            r_rdata_en  <= 1'b0;
            r_addr      <= '0;
            r_iorq_n    <= 1'b1;
            r_mreq_n    <= 1'b1;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_dout      <= '0;
            r_oe        <= 1'b0;
            r_timeout   <= 1'b0;
            r_wait_meta <= 1'b0;
            r_wait_s    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_phase     <= w_phase;
            r_ext       <= w_ext;
            r_io        <= w_io;
            r_wr        <= w_wr;
            r_ready     <= w_ready;
            r_rdata     <= w_rdata;
            r_rdata_en  <= w_rdata_en;
            r_addr      <= w_addr;
            r_iorq_n    <= w_iorq_n;
            r_mreq_n    <= w_mreq_n;
            r_rd_n      <= w_rd_n;
            r_wr_n      <= w_wr_n;
            r_dout      <= w_dout;
            r_oe        <= w_oe;
            r_timeout   <= w_timeout;
            r_wait_meta <= p_slot_wait;
            r_wait_s    <= r_wait_meta;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_phase    = r_phase;
        w_ext      = r_ext;
        w_io       = r_io;
        w_wr       = r_wr;
        w_ready    = r_ready;
        w_rdata    = r_rdata;
        w_rdata_en = 1'b0;
        w_addr     = r_addr;
        w_iorq_n   = r_iorq_n;
        w_mreq_n   = r_mreq_n;
        w_rd_n     = r_rd_n;
        w_wr_n     = r_wr_n;
        w_dout     = r_dout;
        w_oe       = r_oe;
        w_timeout  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus_valid && r_ready) begin
                    w_io    = bus_ioreq;
                    w_wr    = bus_write;
                    w_addr  = bus_address;
                    w_oe    = bus_write;
                    if (bus_write) begin
                        w_dout = bus_wdata;
                    end
                    w_ready = 1'b0;
                    w_phase = '0;
                    w_ext   = '0;
                    w_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_phase == SETUP_LAST) begin
                    w_iorq_n = ~r_io;
                    w_mreq_n = r_io;
                    w_rd_n   = r_wr;
                    w_wr_n   = ~r_wr;
                    w_phase  = '0;
                    w_ext    = '0;
                    w_state  = ST_STROBE;
                end else begin
                    w_phase = r_phase + 8'd1;
                end
            end
            ST_STROBE: begin
                // Phase counter parks at its last value; the extension counter takes over.
                if (r_phase != STROBE_LAST) begin
                    w_phase = r_phase + 8'd1;
                end else if (!r_wait_s || r_ext == EXT_MAX) begin
                    w_iorq_n = 1'b1;
                    w_mreq_n = 1'b1;
                    w_rd_n   = 1'b1;
                    w_wr_n   = 1'b1;
                    w_timeout = r_wait_s;
                    if (!r_wr) begin
                        w_rdata    = r_wait_s ? 8'hFF : p_slot_data_in;
                        w_rdata_en = 1'b1;
                    end
                    w_phase = '0;
                    w_ext   = '0;
                    w_state = ST_HOLD;
                end else begin
                    w_ext = r_ext + 10'd1;
                end
            end
            ST_HOLD: begin
                if (r_phase == HOLD_LAST) begin
                    w_oe    = 1'b0;
                    w_ready = 1'b1;
                    w_phase = '0;
                    w_ext   = '0;
                    w_state = ST_IDLE;
                end else begin
                    w_phase = r_phase + 8'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign bus_ready       = r_ready;
    assign bus_rdata       = r_rdata;
    assign bus_rdata_en    = r_rdata_en;
    assign p_slot_address  = r_addr;
    assign p_slot_iorq_n   = r_iorq_n;
    assign p_slot_mreq_n   = r_mreq_n;
    assign p_slot_rd_n     = r_rd_n;
    assign p_slot_wr_n     = r_wr_n;
    assign p_slot_data_out = r_dout;
    assign p_slot_data_oe  = r_oe;
    assign p_timeout       = r_timeout;

endmodule

// File: tb/tb_msx_slot_master.sv
// Bench for msx_slot_master: two instances (default timeout and WAIT_TIMEOUT=8)
// checked clock by clock against a transaction-level timing model.
module tb_msx_slot_master;

    localparam int unsigned S = 3;
    localparam int unsigned T = 12;
    localparam int unsigned H = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [15:0] t_addr  [2];
    logic        t_io    [2];
    logic        t_wr    [2];
    logic        t_valid [2];
    logic [7:0]  t_wdata [2];
    logic [7:0]  t_din   [2];
    logic        t_wait  [2];

    wire         w_ready   [2];
    wire [7:0]   w_rdata   [2];
    wire         w_rdata_en[2];
    wire [15:0]  w_paddr   [2];
    wire         w_iorq_n  [2];
    wire         w_mreq_n  [2];
    wire         w_rd_n    [2];
    wire         w_wr_n    [2];
    wire [7:0]   w_dout    [2];
    wire         w_oe      [2];
    wire         w_tmo     [2];

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_cnt = 0;
    logic [7:0]  m_rdata [2];
    logic [15:0] mon_prev = '0;
    int          mon_chg = 0;
    int          mon_chg_prev = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        msx_slot_master #(
            .SETUP_CYCLES (S),
            .STROBE_CYCLES(T),
            .HOLD_CYCLES  (H),
            .WAIT_TIMEOUT (gi == 0 ? 1023 : 8)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .bus_address    (t_addr[gi]),
            .bus_ioreq      (t_io[gi]),
            .bus_write      (t_wr[gi]),
            .bus_valid      (t_valid[gi]),
            .bus_ready      (w_ready[gi]),
            .bus_wdata      (t_wdata[gi]),
            .bus_rdata      (w_rdata[gi]),
            .bus_rdata_en   (w_rdata_en[gi]),
            .p_slot_address (w_paddr[gi]),
            .p_slot_iorq_n  (w_iorq_n[gi]),
            .p_slot_mreq_n  (w_mreq_n[gi]),
            .p_slot_rd_n    (w_rd_n[gi]),
            .p_slot_wr_n    (w_wr_n[gi]),
            .p_slot_data_out(w_dout[gi]),
            .p_slot_data_oe (w_oe[gi]),
            .p_slot_data_in (t_din[gi]),
            .p_slot_wait    (t_wait[gi]),
            .p_timeout      (w_tmo[gi])
        );
    end

    // Edge at which the slot address of instance 0 last changed.
    always @(negedge clk) begin
        if (w_paddr[0] !== mon_prev) begin
            mon_prev     = w_paddr[0];
            mon_chg_prev = mon_chg;
            mon_chg      = edge_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int to_of(input int idx);
        return (idx == 0) ? 1023 : 8;
    endfunction

    function automatic bit pin_hi(input int e, input int ws, input int wl);
        return (e >= ws) && (e < ws + wl);
    endfunction

    task automatic check_idle(input int idx, input string tg, input logic rdy);
        check({tg, " ready"},   32'(w_ready[idx]),    32'(rdy));
        check({tg, " rdata"},   32'(w_rdata[idx]),    32'(8'hFF));
        check({tg, " rdata_en"},32'(w_rdata_en[idx]), 32'(0));
        check({tg, " addr"},    32'(w_paddr[idx]),    32'(0));
        check({tg, " strobes"}, 32'({w_iorq_n[idx], w_mreq_n[idx], w_rd_n[idx], w_wr_n[idx]}), 32'(4'hF));
        check({tg, " dout"},    32'(w_dout[idx]),     32'(0));
        check({tg, " oe"},      32'(w_oe[idx]),       32'(0));
        check({tg, " timeout"}, 32'(w_tmo[idx]),      32'(0));
    endtask

    // One transfer; pin WAIT is high at edges ws..ws+wl-1 counted from the accept edge.
    task automatic xfer(input int idx, input logic [15:0] a, input logic io, input logic wr,
                        input logic [7:0] wd, input logic [7:0] rd,
                        input int ws, input int wl, input bit hold_valid);
        int    end_e;
        bit    abort;
        bit    low;
        string tg;
        end_e = S + T;
        abort = 0;
        while (pin_hi(end_e - 2, ws, wl)) begin
            if (end_e == int'(S + T) + to_of(idx)) begin
                abort = 1;
                break;
            end
            end_e++;
        end
        check($sformatf("u%0d ready_idle", idx), 32'(w_ready[idx]), 32'(1));
        t_addr[idx]  = a;
        t_io[idx]    = io;
        t_wr[idx]    = wr;
        t_wdata[idx] = wd;
        t_valid[idx] = 1'b1;
        for (int j = 0; j <= end_e + int'(H); j++) begin
            t_wait[idx] = pin_hi(j, ws, wl);
            t_din[idx]  = (j == end_e) ? rd : 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (j == 0) begin
                if (!hold_valid) t_valid[idx] = 1'b0;
                t_addr[idx]  = 16'($urandom);
                t_io[idx]    = 1'($urandom);
                t_wr[idx]    = 1'($urandom);
                t_wdata[idx] = 8'($urandom);
            end
            low = (j >= int'(S)) && (j < end_e);
            tg  = $sformatf("u%0d a%04h j%0d", idx, a, j);
            check({tg, " addr"},     32'(w_paddr[idx]),    32'(a));
            check({tg, " iorq_n"},   32'(w_iorq_n[idx]),   32'(!(low && io)));
            check({tg, " mreq_n"},   32'(w_mreq_n[idx]),   32'(!(low && !io)));
            check({tg, " rd_n"},     32'(w_rd_n[idx]),     32'(!(low && !wr)));
            check({tg, " wr_n"},     32'(w_wr_n[idx]),     32'(!(low && wr)));
            check({tg, " oe"},       32'(w_oe[idx]),       32'(wr && (j < end_e + int'(H))));
            if (wr) check({tg, " dout"}, 32'(w_dout[idx]), 32'(wd));
            check({tg, " ready"},    32'(w_ready[idx]),    32'(j >= end_e + int'(H)));
            check({tg, " rdata_en"}, 32'(w_rdata_en[idx]), 32'(!wr && (j == end_e)));
            check({tg, " timeout"},  32'(w_tmo[idx]),      32'(abort && (j == end_e)));
            if (!wr && j == end_e) m_rdata[idx] = abort ? 8'hFF : rd;
            check({tg, " rdata"},    32'(w_rdata[idx]),    32'(m_rdata[idx]));
        end
        t_wait[idx] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            t_addr[i] = '0; t_io[i] = 1'b0; t_wr[i] = 1'b0; t_valid[i] = 1'b0;
            t_wdata[i] = '0; t_din[i] = '0; t_wait[i] = 1'b0; m_rdata[i] = 8'hFF;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_idle(i, $sformatf("u%0d in_reset", i), 1'b0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("u%0d ready_at_release", i), 32'(w_ready[i]), 32'(0));
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_idle(i, $sformatf("u%0d after_release", i), 1'b1);

        xfer(0, 16'h0098, 1'b1, 1'b1, 8'h5A, 8'h00, 0, 0, 1'b0);
        xfer(0, 16'h4000, 1'b0, 1'b0, 8'h00, 8'hC3, 0, 0, 1'b0);
        xfer(0, 16'h2233, 1'b1, 1'b0, 8'h00, 8'h7E, 5, 20, 1'b0);
        xfer(1, 16'h8001, 1'b0, 1'b0, 8'h00, 8'h11, 0, 100000, 1'b0);
        xfer(1, 16'h0099, 1'b1, 1'b1, 8'h42, 8'h00, 0, 100000, 1'b0);

        xfer(0, 16'h1234, 1'b0, 1'b1, 8'hA5, 8'h00, 0, 0, 1'b1);
        xfer(0, 16'h5678, 1'b1, 1'b0, 8'h00, 8'h96, 0, 0, 1'b1);
        t_valid[0] = 1'b0;
        check("b2b addr spacing", 32'(mon_chg - mon_chg_prev), 32'(S + T + H + 1));

        for (int n = 0; n < 40; n++) begin
            int idx;
            int wl;
            idx = int'($urandom_range(0, 1));
            wl  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
            xfer(idx, 16'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 25)), wl, 1'($urandom));
            t_valid[idx] = 1'b0;
        end

        // Reset in the middle of a write strobe.
        t_addr[0] = 16'h00A0; t_io[0] = 1'b1; t_wr[0] = 1'b1; t_wdata[0] = 8'h3C; t_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_valid[0] = 1'b0;
        repeat (S + 4) @(posedge clk);
        @(negedge clk);
        check("rst pre strobe low", 32'({w_iorq_n[0], w_wr_n[0]}), 32'(0));
        reset = 1'b1;
        #1;
        m_rdata[0] = 8'hFF;
        m_rdata[1] = 8'hFF;
        check_idle(0, "rst async", 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_idle(0, "rst held", 1'b0);
        end
        reset = 1'b0;
        #1;
        check("rst release ready", 32'(w_ready[0]), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check_idle(0, "rst recovered", 1'b1);
        check("u1 rst recovered ready", 32'(w_ready[1]), 32'(1));
        xfer(0, 16'hBEEF, 1'b0, 1'b0, 8'h00, 8'h5C, 2, 30, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/msx_slot_master.md
# msx_slot_master

Initiator for the MSX cartridge slot bus, the counterpart of `msx_slot`. It accepts single-byte requests on the internal valid/ready bus used throughout the cartridge (`bus_address`/`bus_ioreq`/`bus_write`/`bus_valid`/`bus_ready`/`bus_wdata`/`bus_rdata`/`bus_rdata_en`). It executes each request as one Z80-style I/O or memory cycle on the slot pins, including WAIT extension and timeout. It sits between an internal master (test sequencer, DMA, or bridge) and the pin-level slot interface, on the 42.95454MHz `clk42m` domain.

## Interface
Parameters:
- `SETUP_CYCLES`, 3: clocks address (and write data) are valid before the strobe falls, 1..255.
- `STROBE_CYCLES`, 12: minimum strobe-low clocks, 1..255.
- `HOLD_CYCLES`, 3: clocks address/data are held after the strobe rises, 1..255.
- `WAIT_TIMEOUT`, 1023: maximum WAIT extension clocks before abort, 1..1023.

Ports:
- `clk` input 1: clk42m; the only clock.
- `reset` input 1: asynchronous, active-high.
- `bus_address` input 16: request address.
- `bus_ioreq` input 1: 1 = I/O cycle (IORQ), 0 = memory cycle (MREQ).
- `bus_write` input 1: 1 = write, 0 = read.
- `bus_valid` input 1: request present.
- `bus_ready` output 1: block can accept a request.
- `bus_wdata` input 8: write data.
- `bus_rdata` output 8: read data.
- `bus_rdata_en` output 1: one-clock pulse; `bus_rdata` valid.
- `p_slot_address` output 16: slot address pins.
- `p_slot_iorq_n`, `p_slot_mreq_n`, `p_slot_rd_n`, `p_slot_wr_n` output 1 each: slot strobes, active-low.
- `p_slot_data_out` output 8: data driven to the slot.
- `p_slot_data_oe` output 1: 1 = drive `p_slot_data_out` onto the pins.
- `p_slot_data_in` input 8: data sampled from the pins.
- `p_slot_wait` input 1: slot WAIT, active-high, asynchronous.
- `p_timeout` output 1: one-clock pulse when a cycle is aborted.

## Operation
- All outputs are registered.
- Reset values:
  - `bus_ready`=0, `bus_rdata`=8'hFF, `bus_rdata_en`=0.
  - `p_slot_address`=0.
  - All four strobes =1.
  - `p_slot_data_out`=0, `p_slot_data_oe`=0.
  - `p_timeout`=0.
  - State = IDLE, all counters = 0.
- `p_slot_wait` passes through a 2-flop synchronizer (`wait_s`), which resets to 0.
- States:
  - IDLE: `bus_ready`=1. A transfer is accepted on a clock where `bus_valid` & `bus_ready`. At that edge the block latches address, ioreq, write and wdata, drives `p_slot_address`, and drives `p_slot_data_out`/`p_slot_data_oe`=1 if the request is a write. It clears `bus_ready` and goes to SETUP.
  - SETUP: lasts SETUP_CYCLES clocks. At the final edge, assert `iorq_n` or `mreq_n` (per ioreq) together with `rd_n` or `wr_n` (per write), all low, and go to STROBE.
  - STROBE: lasts at least STROBE_CYCLES clocks. Once the minimum has elapsed, the strobe ends at the first edge where `wait_s`=0. While `wait_s`=1 an extension counter increments. If the counter reaches WAIT_TIMEOUT, the cycle aborts.
    - Normal end edge: all strobes go to 1. For a read, `bus_rdata` <= `p_slot_data_in` and `bus_rdata_en` <= 1. Go to HOLD.
    - Abort edge: all strobes go to 1 and `p_timeout` <= 1. For a read, `bus_rdata` <= 8'hFF and `bus_rdata_en` <= 1. Go to HOLD.
  - HOLD: lasts HOLD_CYCLES clocks with address and data/oe unchanged. At the final edge `p_slot_data_oe` <= 0, `bus_ready` <= 1, and the state returns to IDLE. `p_slot_address` keeps its last value.
- Writes never pulse `bus_rdata_en`. `bus_rdata` holds its value until the next read completes.
- `bus_address`, `bus_ioreq`, `bus_write` and `bus_wdata` are ignored outside the accept edge.
- Inputs that change mid-cycle have no effect.
- `bus_valid` while `bus_ready`=0 is not accepted. The requester holds it until it is accepted.
- Only one strobe pair is ever low at a time. `rd_n` and `wr_n` are never simultaneously low.
- Reset asserted mid-cycle: all outputs go to their reset values immediately (asynchronously). No `bus_rdata_en` or `p_timeout` pulse is produced, and the aborted transfer is lost.
- Counters: 8-bit phase counter, 10-bit extension counter; both clear on entry to each state.

## Timing
- Accept edge = edge 0. `bus_ready` is low from edge 0.
- Address and write data are on the pins for clocks 1..S, with S = SETUP_CYCLES.
- Strobe is low for clocks S+1 .. S+T+E, with T = STROBE_CYCLES and E = extension clocks.
- Read data is sampled at edge S+T+E. `bus_rdata_en` is high for clock S+T+E+1.
- HOLD covers clocks S+T+E+1 .. S+T+E+H.
- `bus_ready`=1 from clock S+T+E+H+1. With the defaults and no WAIT, that is clock 19.
- Minimum back-to-back spacing is S+T+H+1 clocks per transfer.
- WAIT latency is 2 clocks from the pin to `wait_s`. A WAIT must assert by clock S+T-2 to extend the cycle.
- First `bus_ready`=1 is the clock after reset deasserts.

## Test plan
- Defaults, I/O write to address 16'h0098 with data 8'h5A:
  - `iorq_n` and `wr_n` low for exactly 12 clocks, starting 3 clocks after the address appears.
  - `mreq_n` and `rd_n` stay at 1.
  - Data oe is high from clock 1 through clock 18.
  - `bus_ready` returns at clock 19; no `bus_rdata_en` pulse.
- Defaults, memory read from 16'h4000 with `p_slot_data_in`=8'hC3:
  - `mreq_n` and `rd_n` are low for 12 clocks.
  - `bus_rdata`=8'hC3, with `bus_rdata_en` a single pulse on clock 16.
- I/O read with `p_slot_wait` held high for 20 clocks starting at clock 5:
  - Strobe low-time is extended to match the synchronized wait.
  - Data is sampled on the first clock where `wait_s`=0 after the minimum strobe time; no `p_timeout`.
- `WAIT_TIMEOUT`=8 with `p_slot_wait` stuck at 1 on a read:
  - `p_timeout` pulses once.
  - `bus_rdata`=8'hFF with `bus_rdata_en` pulsed; the strobe released after 12+8 clocks.
  - `bus_ready` returns 3 clocks later.
- Two requests back-to-back with `bus_valid` held high:
  - Second accept occurs exactly on the clock `bus_ready` returns.
  - Spacing between address changes is 19 clocks; no strobe overlap.
- `reset` pulsed during STROBE of a write:
  - All strobes and `p_slot_data_oe` reach their reset values without waiting for a clock edge.
  - No `bus_rdata_en`, `p_timeout` or `bus_ready` until the clock after reset is released.
